uart_rx_frontend: RTL
=====================

# uart_rx_frontend

Serial-to-parallel UART receiver that recovers 8N1 frames from the asynchronous `rx_serial` pin and presents each received byte as `ascii_data` with a one-cycle `data_valid` strobe. It sits directly upstream of the seven-segment serial display stage and drives that stage's `ascii_data`/`data_valid` inputs unchanged. It also flags malformed frames so board-level logic can count line errors.

## Interface
- `CLKS_PER_BIT`, 868, `clk_in` cycles per UART bit (100 MHz / 115200 baud); legal range 8..65535.
- `clk_in`  input  1  system clock; every register is clocked on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `rx_serial`  input  1  raw UART line, idle high, asynchronous to `clk_in`.
- `ascii_data`  output  8  last correctly framed byte, LSB received first.
- `data_valid`  output  1  one-cycle pulse; `ascii_data` is new in this cycle.
- `frame_error`  output  1  one-cycle pulse; stop bit sampled low.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- Input synchronizer: two flops, `rx_s` = `rx_serial` delayed 2 cycles. Both flops reset to 1, the idle line level.
- Bit counter `cnt`: width clog2(CLKS_PER_BIT). Bit index `idx`: 3 bits. Shift register `sh`: 8 bits. `HALF` = CLKS_PER_BIT/2, integer division.
- States and transitions:
  - IDLE: when `rx_s`==0, go to START, `cnt`←0.
  - START: `cnt` increments each cycle. At `cnt`==HALF-1, sample the line.
    - Sample 0: go to DATA, `cnt`←0, `idx`←0.
    - Sample 1: glitch; return to IDLE with no output.
  - DATA: at `cnt`==CLKS_PER_BIT-1, sample the line, `sh`←{sample, sh[7:1]}, `cnt`←0.
    - After the sample with `idx`==7, go to STOP.
    - Otherwise `idx`←`idx`+1.
  - STOP: at `cnt`==CLKS_PER_BIT-1, sample the line.
    - Sample 1: `ascii_data`←`sh`, `data_valid`←1, go to IDLE.
    - Sample 0: `frame_error`←1, `ascii_data` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. No start bit is detected while in BREAK.
- Back-to-back frames: STOP returns to IDLE at mid-stop-bit, so a start bit arriving right after the nominal stop bit is caught.
- `data_valid` and `frame_error` are registered, and are never high in the same cycle.
- `ascii_data` holds its value between frames.
- Reset, asserted at any time including mid-frame:
  - Takes effect immediately; state returns to IDLE.
  - `ascii_data`=8'h00, `data_valid`=0, `frame_error`=0, `busy`=0.
  - `cnt`, `idx` and `sh` are cleared.
  - A partially received byte is discarded.

## Timing
- Reference point: cycle 0 is the first `clk_in` edge at which `rx_s` is seen low in IDLE.
  - START is entered at edge 0.
  - Start-bit check at edge HALF.
  - Data bit n is sampled at edge HALF + (n+1)·CLKS_PER_BIT, for n = 0..7.
  - Stop-bit sample at edge HALF + 9·CLKS_PER_BIT.
  - `data_valid` is high for the one cycle following that edge.
- `busy` rises the cycle after cycle 0. It falls the cycle after the stop sample on a good frame, or after BREAK exits.
- Pin-to-strobe latency = 2 (synchronizer) + HALF + 9·CLKS_PER_BIT + 1 cycles.
- Tolerated baud mismatch: about ±4 % at the default setting.

## Configuration
- `UART_RX_MAJORITY_EN` defined: every sample point (start check, data bits, stop bit) uses the majority of three `rx_s` values.
  - The values are taken at target count −2, −1 and the target count itself; the decision is made at the target count.
  - Sample timing and all outputs are otherwise unchanged.
  - A single-cycle line glitch inside a bit never corrupts the result.
- `UART_RX_MAJORITY_EN` undefined: single sample of `rx_s` at the target count.

## Test plan
- Reset state: assert `rst` asynchronously between clock edges → all outputs 0 immediately, with no clock needed.
- Single frame: CLKS_PER_BIT=16, send 8'h41 ('A') → exactly one `data_valid` pulse with `ascii_data`=8'h41. Pulse lands at 2+8+144+1 cycles after the falling edge on `rx_serial`, ±1 cycle for synchronizer phase.
- Back-to-back: send "0", "9", "F" with no idle gap → three `data_valid` pulses carrying 8'h30, 8'h39, 8'h46, with no `frame_error`.
- False start: drive a 3-cycle low glitch on idle `rx_serial` → return to IDLE, no `data_valid`, no `frame_error`.
- Framing error: send 8'h55 with the stop bit held low for 20 bit times → one `frame_error` pulse, `ascii_data` keeps its previous value, and `busy` stays high until the line returns high. A following 8'h31 is received correctly.
- Mid-frame reset: pulse `rst` during data bit 4 of 8'h7E, then send 8'h32 → no output for 8'h7E, and `ascii_data`=8'h32 with one `data_valid`. With `UART_RX_MAJORITY_EN` defined, a 1-cycle inverted glitch at each bit centre still yields 8'h32.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: 2-flop synchronizer, start-bit validation, byte strobe and framing-error flag.
// Define UART_RX_MAJORITY_EN to take a 3-sample majority vote at every sample point.
module uart_rx_frontend #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] ascii_data,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_s;
    logic             sample;

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rx_s one cycle back, hist_q[1] two cycles back.
    logic [1:0] hist_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= {hist_q[0], rx_s};
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign sample = rx_s;
`endif

    // Synchronizer resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop see pre-edge values, independent of statement order.
            sync_q  <= {sync_q[0], rx_serial};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    if (!sample) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    sh_d  = {sample, sh_q[7:1]};
                    cnt_d = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit of margin to catch a back-to-back start.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (sample) begin
                        data_d  = sh_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ascii_data  = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != S_IDLE);

endmodule
